// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the FFT post-processing blocks.
package fft_pkg;

  localparam int N_FFT  = 32;
  localparam int DATA_W = 32;
  localparam int BIN_W  = $clog2(N_FFT);
  localparam int MAG_W  = 2 * DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    REPORT
  } state_t;

endpackage

// File: rtl/cplx_mag_sq.sv
// Two-stage registered |X|^2 unit: S1 squares re/im, S2 sums them.
// An opaque tag and a valid bit ride alongside the data.
module cplx_mag_sq #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int TAG_W  = fft_pkg::BIN_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [TAG_W-1:0]    tag,
  input  logic [DATA_W-1:0]   re,
  input  logic [DATA_W-1:0]   im,
  output logic                mag_valid,
  output logic [TAG_W-1:0]    mag_tag,
  output logic [2*DATA_W:0]   mag
);

  // Sign-extended operands; the low 2*DATA_W bits of their product are the exact square.
  logic [2*DATA_W-1:0] re_x;
  logic [2*DATA_W-1:0] im_x;
  logic [2*DATA_W-1:0] re_sq;
  logic [2*DATA_W-1:0] im_sq;
  logic                s1_valid;
  logic [TAG_W-1:0]    s1_tag;

  assign re_x = {{DATA_W{re[DATA_W-1]}}, re};
  assign im_x = {{DATA_W{im[DATA_W-1]}}, im};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_tag    <= '0;
      re_sq     <= '0;
      im_sq     <= '0;
      mag_valid <= 1'b0;
      mag_tag   <= '0;
      mag       <= '0;
    end else begin
      s1_valid  <= valid;
      s1_tag    <= tag;
      re_sq     <= re_x * re_x;
      im_sq     <= im_x * im_x;
      mag_valid <= s1_valid;
      mag_tag   <= s1_tag;
      mag       <= {1'b0, re_sq} + {1'b0, im_sq};
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak detector on the serial FFT bin stream: reports bin, |X|^2 and Hz.
// Build option PEAK_THRESH_EN: peak_present compares against MIN_MAG instead of non-zero.
module fft_peak_detect
  import fft_pkg::state_t, fft_pkg::IDLE, fft_pkg::ACCUM, fft_pkg::FLUSH, fft_pkg::REPORT;
#(
  parameter int N       = 32,
  parameter int DATA_W  = 32,
  parameter int FS_HZ   = 48000,
  parameter int FREQ_W  = 32,
  parameter int MIN_MAG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_W-1:0]     in_re,
  input  logic [DATA_W-1:0]     in_im,
  output logic                  peak_valid,
  output logic [$clog2(N)-1:0]  peak_bin,
  output logic [2*DATA_W:0]     peak_mag,
  output logic [FREQ_W-1:0]     peak_freq,
  output logic                  peak_present,
  output logic                  frame_err
);

  localparam int BW     = $clog2(N);
  localparam int MW     = 2 * DATA_W + 1;
  localparam int BIN_HZ = FS_HZ / N;

  state_t          state;
  logic [BW-1:0]   cnt;
  logic [1:0]      flush_cnt;
  logic            epoch;
  logic [MW-1:0]   max_mag;
  logic [BW-1:0]   max_bin;

  logic            start;
  logic            abort;
  logic            take;
  logic [BW-1:0]   beat_bin;
  logic            beat_epoch;

  logic            mag_valid;
  logic [BW:0]     mag_tag;
  logic [MW-1:0]   mag;
  logic            qualifies;
  logic [63:0]     freq_full;
  logic            present;

  // Beats of an aborted frame still in the pipeline carry the old epoch and are ignored.
  always_comb begin
    start      = 1'b0;
    abort      = 1'b0;
    take       = 1'b0;
    beat_bin   = cnt;
    beat_epoch = epoch;
    if (in_valid) begin
      case (state)
        IDLE: begin
          if (in_sof) begin
            start    = 1'b1;
            take     = 1'b1;
            beat_bin = '0;
          end
        end
        ACCUM: begin
          take = 1'b1;
          if (in_sof && cnt != '0) begin
            abort      = 1'b1;
            beat_bin   = '0;
            beat_epoch = ~epoch;
          end
        end
        default: ;
      endcase
    end
  end

  cplx_mag_sq #(
    .DATA_W (DATA_W),
    .TAG_W  (BW + 1)
  ) u_mag (
    .clk       (clk),
    .reset     (reset),
    .valid     (take),
    .tag       ({beat_epoch, beat_bin}),
    .re        (in_re),
    .im        (in_im),
    .mag_valid (mag_valid),
    .mag_tag   (mag_tag),
    .mag       (mag)
  );

  // Only bins 1..N/2-1 compete: skip DC and the mirrored upper half.
  assign qualifies = mag_valid && (mag_tag[BW] == epoch) &&
                     (mag_tag[BW-1:0] != '0) && !mag_tag[BW-1];

  assign freq_full = 64'(max_bin) * 64'(BIN_HZ);

`ifdef PEAK_THRESH_EN
  localparam logic [MW-1:0] MIN_THRESH = MW'(MIN_MAG);
  assign present = (max_mag >= MIN_THRESH);
`else
  assign present = (max_mag != '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      flush_cnt    <= '0;
      epoch        <= 1'b0;
      max_mag      <= '0;
      max_bin      <= '0;
      peak_valid   <= 1'b0;
      peak_bin     <= '0;
      peak_mag     <= '0;
      peak_freq    <= '0;
      peak_present <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (start || abort) begin
        max_mag <= '0;
        max_bin <= '0;
      end else if (qualifies && mag > max_mag) begin
        max_mag <= mag;
        max_bin <= mag_tag[BW-1:0];
      end

      if (abort)
        epoch <= ~epoch;

      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= BW'(1);
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (abort) begin
            cnt       <= BW'(1);
            frame_err <= 1'b1;
          end else if (in_valid) begin
            if (cnt == BW'(N - 1)) begin
              cnt       <= '0;
              flush_cnt <= '0;
              state     <= FLUSH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (in_valid && in_sof)
            frame_err <= 1'b1;
          if (flush_cnt == 2'd2)
            state <= REPORT;
          else
            flush_cnt <= flush_cnt + 1'b1;
        end
        REPORT: begin
          if (in_valid && in_sof)
            frame_err <= 1'b1;
          peak_valid   <= 1'b1;
          peak_bin     <= max_bin;
          peak_mag     <= max_mag;
          peak_freq    <= freq_full[FREQ_W-1:0];
          peak_present <= present;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: directed frames push expected reports,
// a negedge monitor pops and compares each peak_valid pulse.
module tb_fft_peak_detect;

`ifdef PEAK_THRESH_EN
  localparam int TB_MIN_MAG = 1000000;
`else
  localparam int TB_MIN_MAG = 1;
`endif

  typedef struct {
    logic [4:0]  bin;
    logic [64:0] mag;
    logic [31:0] freq;
    logic        present;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_sof;
  logic [31:0] in_re;
  logic [31:0] in_im;
  logic        peak_valid;
  logic [4:0]  peak_bin;
  logic [64:0] peak_mag;
  logic [31:0] peak_freq;
  logic        peak_present;
  logic        frame_err;

  logic signed [31:0] fre [32];
  logic signed [31:0] fim [32];
  exp_t exp_q[$];
  int   cyc = 0;
  int   err_seen = 0;
  int   checks = 0;
  int   failures = 0;
  int   dc;

  fft_peak_detect #(
    .N       (32),
    .DATA_W  (32),
    .FS_HZ   (48000),
    .FREQ_W  (32),
    .MIN_MAG (TB_MIN_MAG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_re        (in_re),
    .in_im        (in_im),
    .peak_valid   (peak_valid),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .peak_freq    (peak_freq),
    .peak_present (peak_present),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic expPresent(input logic [64:0] m);
`ifdef PEAK_THRESH_EN
    return m >= 65'(TB_MIN_MAG);
`else
    return m != 0;
`endif
  endfunction

  task automatic pushExp(input int bin, input logic [64:0] mag, input int freq, input int drive_cyc);
    exp_q.push_back('{5'(bin), mag, 32'(freq), expPresent(mag), drive_cyc + 5});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (frame_err) err_seen++;
    if (peak_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_peak actual=bin%0d required=no report", peak_bin);
      end else begin
        e = exp_q.pop_front();
        checkOutput("peak_bin", 65'(peak_bin), 65'(e.bin));
        checkOutput("peak_mag", peak_mag, e.mag);
        checkOutput("peak_freq", 65'(peak_freq), 65'(e.freq));
        checkOutput("peak_present", 65'(peak_present), 65'(e.present));
        checkOutput("peak_latency", 65'(cyc), 65'(e.cyc));
      end
    end
  end

  task automatic applyStimulus(input int idx, input bit gapped, output int drive_cyc);
    @(negedge clk);
    drive_cyc = cyc;
    in_valid  = 1'b1;
    in_sof    = (idx == 0);
    in_re     = fre[idx];
    in_im     = fim[idx];
    if (gapped) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  task automatic sendFrame(input bit gapped, input int upto, output int drive_cyc);
    for (int i = 0; i <= upto; i++) applyStimulus(i, gapped, drive_cyc);
  endtask

  task automatic release_bus();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic clearFrame();
    for (int i = 0; i < 32; i++) begin
      fre[i] = '0;
      fim[i] = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_valid"}, 65'(peak_valid), 65'(0));
    checkOutput({tag, "_bin"}, 65'(peak_bin), 65'(0));
    checkOutput({tag, "_mag"}, peak_mag, 65'(0));
    checkOutput({tag, "_freq"}, 65'(peak_freq), 65'(0));
    checkOutput({tag, "_present"}, 65'(peak_present), 65'(0));
    checkOutput({tag, "_err"}, 65'(frame_err), 65'(0));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_re    = '0;
    in_im    = '0;
    clearFrame();
    idle(3);
    checkZeroOutputs("reset");
    reset = 1'b0;
    idle(2);

    // Single tone in bin 5
    clearFrame();
    fre[5] = 1000;
    sendFrame(1'b0, 31, dc);
    pushExp(5, 65'd1000000, 7500, dc);
    release_bus();
    idle(8);

    // Complex value beats a smaller real bin; stray sof during FLUSH
    clearFrame();
    fre[9] = -3000;
    fim[9] = 4000;
    fre[2] = 4000;
    sendFrame(1'b0, 31, dc);
    pushExp(9, 65'd25000000, 13500, dc);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_re    = 32'd77777;
    release_bus();
    idle(8);
    checkOutput("frame_err_flush", 65'(err_seen), 65'(1));

    // DC and mirror excluded; tie keeps lower bin
    clearFrame();
    fre[0]  = 50000;
    fre[20] = 60000;
    fre[3]  = 200;
    fre[7]  = 200;
    sendFrame(1'b0, 31, dc);
    pushExp(3, 65'd40000, 4500, dc);
    release_bus();
    idle(8);

    // Abort at beat 12: earlier larger bins must not leak into the restarted frame
    clearFrame();
    fre[5]  = 5000;
    fre[11] = 7000;
    sendFrame(1'b0, 11, dc);
    clearFrame();
    fre[10] = 2000;
    sendFrame(1'b0, 31, dc);
    pushExp(10, 65'd4000000, 15000, dc);
    release_bus();
    idle(8);
    checkOutput("frame_err_abort", 65'(err_seen), 65'(2));

    // Reset at beat 20 discards the frame and zeroes outputs
    clearFrame();
    fre[6] = 3000;
    sendFrame(1'b0, 19, dc);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    idle(2);
    reset = 1'b0;
    checkZeroOutputs("midreset");
    idle(12);
    checkOutput("frame_err_after_reset", 65'(err_seen), 65'(2));

    // Gapped input gives the same result and fixed latency
    clearFrame();
    fre[9] = -3000;
    fim[9] = 4000;
    fre[2] = 4000;
    sendFrame(1'b1, 31, dc);
    pushExp(9, 65'd25000000, 13500, dc);
    idle(8);

    // All-zero frame
    clearFrame();
    sendFrame(1'b0, 31, dc);
    pushExp(0, 65'd0, 0, dc);
    release_bus();
    idle(8);

    // Tone just under 1e6
    clearFrame();
    fre[5] = 999;
    sendFrame(1'b0, 31, dc);
    pushExp(5, 65'd998001, 7500, dc);
    release_bus();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL missing_peak actual=none required=bin%0d", e.bin);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
